// File: rtl/fir_filter_if.sv
// Sample-stream bundle for fir_filter: x_in from the source, y_out to consumers.
interface fir_filter_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_out;

  modport master (output x_in, input  y_out);
  modport slave  (input  x_in, output y_out);
endinterface

// File: rtl/fir_filter.sv
// Eight-tap direct-form FIR on a Q4.12 stream, one rounded registered output per clock.
// Define FIR_SATURATE_EN to clamp out-of-range results; otherwise they wrap to WIDTH bits.
module fir_filter #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 12,
  parameter logic [8*WIDTH-1:0] COEFFS = {16'hFFC0, 16'h0000, 16'h0240, 16'h0600,
                                          16'h0600, 16'h0240, 16'h0000, 16'hFFC0}
) (
  input  logic         clk,
  input  logic         rst,
  fir_filter_if.slave  bus
);

  localparam int NTAPS = 8;
  localparam int ACC_W = 2*WIDTH + 3;
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< (FRAC-1);

  // History only needs x[n-1]..x[n-7]; x[n] comes straight from the input.
  logic signed [WIDTH-1:0] r_d [1:NTAPS-1];
  logic signed [WIDTH-1:0] r_y;

  logic signed [WIDTH-1:0] w_x [0:NTAPS-1];
  logic signed [WIDTH-1:0] w_h [0:NTAPS-1];
  logic signed [ACC_W-1:0] w_acc;
  logic signed [WIDTH-1:0] w_y;

  always_comb begin
    w_x[0] = bus.x_in;
    for (int unsigned k = 1; k < NTAPS; k++) begin
      w_x[k] = r_d[k];
    end
  end

  // MSB slice of COEFFS is h[0].
  always_comb begin
    for (int unsigned k = 0; k < NTAPS; k++) begin
      w_h[k] = COEFFS[(NTAPS-1-k)*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    w_acc = '0;
    for (int unsigned k = 0; k < NTAPS; k++) begin
      w_acc = w_acc + ACC_W'(w_x[k] * w_h[k]);
    end
  end

`ifdef FIR_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  logic signed [ACC_W-1:0] w_res;

  always_comb begin
    w_res = (w_acc + RND) >>> FRAC;
    w_y   = WIDTH'(w_res);
    if (w_res > SMAX) begin
      w_y = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (w_res < SMIN) begin
      w_y = {1'b1, {(WIDTH-1){1'b0}}};
    end
  end
`else
  always_comb begin
    w_y = WIDTH'((w_acc + RND) >>> FRAC);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 1; k < NTAPS; k++) begin
        r_d[k] <= '0;
      end
      r_y <= '0;
    end else begin
      r_d[1] <= bus.x_in;
      for (int unsigned k = 2; k < NTAPS; k++) begin
        r_d[k] <= r_d[k-1];
      end
      r_y <= w_y;
    end
  end

  assign bus.y_out = r_y;

endmodule

// File: tb/tb_fir_filter.sv
// Directed-vector bench for fir_filter: reset, impulse, rounding, DC step, overflow, mid-run reset.
module tb_fir_filter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fir_filter_if #(.WIDTH(16)) u_if ();

  fir_filter #(
    .WIDTH (16),
    .FRAC  (12)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Caller sits at a falling edge; drives x, waits for the capturing edge, settles 1 time unit.
  task automatic apply(input logic [15:0] v);
    u_if.x_in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic next_negedge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    u_if.x_in = 16'h0000;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    u_if.x_in = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (u_if.y_out !== 16'h0000) begin
        failures++;
        $display("FAIL reset_hold[%0d] y_out=%h expected=0000", i, u_if.y_out);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_impulse();
    logic [15:0] exp_y [0:9] = '{16'hFFC0, 16'h0000, 16'h0240, 16'h0600, 16'h0600,
                                 16'h0240, 16'h0000, 16'hFFC0, 16'h0000, 16'h0000};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      apply((i == 0) ? 16'h1000 : 16'h0000);
      checks++;
      if (u_if.y_out !== exp_y[i]) begin
        failures++;
        $display("FAIL impulse[%0d] y_out=%h expected=%h", i, u_if.y_out, exp_y[i]);
      end
      next_negedge();
    end
  endtask

  task automatic test_rounding();
    logic [15:0] exp_y [0:7] = '{16'h0000, 16'h0000, 16'h0001, 16'h0002,
                                 16'h0002, 16'h0001, 16'h0000, 16'h0000};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      apply((i == 0) ? 16'h0004 : 16'h0000);
      checks++;
      if (u_if.y_out !== exp_y[i]) begin
        failures++;
        $display("FAIL rounding[%0d] y_out=%h expected=%h", i, u_if.y_out, exp_y[i]);
      end
      next_negedge();
    end
  endtask

  task automatic test_dc_step();
    logic [15:0] exp_y [0:10] = '{16'hFFC0, 16'hFFC0, 16'h0200, 16'h0800, 16'h0E00, 16'h1040,
                                  16'h1040, 16'h1000, 16'h1000, 16'h1000, 16'h1000};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      apply(16'h1000);
      checks++;
      if (u_if.y_out !== exp_y[i]) begin
        failures++;
        $display("FAIL dc_step[%0d] y_out=%h expected=%h", i, u_if.y_out, exp_y[i]);
      end
      next_negedge();
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_last;
`ifdef FIR_SATURATE_EN
    exp_last = 16'h7FFF;
`else
    exp_last = 16'h87FF;
`endif
    do_reset();
    apply(16'h8000);
    checks++;
    if (u_if.y_out !== 16'h0200) begin
      failures++;
      $display("FAIL overflow_first y_out=%h expected=0200", u_if.y_out);
    end
    next_negedge();
    for (int i = 0; i < 6; i++) begin
      apply(16'h7FFF);
      next_negedge();
    end
    apply(16'h8000);
    checks++;
    if (u_if.y_out !== exp_last) begin
      failures++;
      $display("FAIL overflow_8th y_out=%h expected=%h", u_if.y_out, exp_last);
    end
    next_negedge();
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_y [0:2] = '{16'hFFC0, 16'h0000, 16'h0240};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply((i == 0) ? 16'h1000 : 16'h0000);
      checks++;
      if (u_if.y_out !== exp_y[i]) begin
        failures++;
        $display("FAIL reset_mid_pre[%0d] y_out=%h expected=%h", i, u_if.y_out, exp_y[i]);
      end
      if (i < 2) next_negedge();
    end
    // Assert reset between edges: output must clear without waiting for a clock.
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (u_if.y_out !== 16'h0000) begin
      failures++;
      $display("FAIL reset_async y_out=%h expected=0000", u_if.y_out);
    end
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      apply(16'h0000);
      checks++;
      if (u_if.y_out !== 16'h0000) begin
        failures++;
        $display("FAIL reset_mid_post[%0d] y_out=%h expected=0000", i, u_if.y_out);
      end
      next_negedge();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    u_if.x_in = 16'h0000;
    @(negedge clk);
    test_reset();
    test_impulse();
    test_rounding();
    test_dc_step();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
